// File: rtl/freqtable_arbiter_pkg.sv
// Shared defaults and channel-state encoding for the frequency-table lookup arbiter.
package freqtable_pkg;

  localparam int NCH_DEF    = 16;
  localparam int AW_DEF     = 10;
  localparam int DW_DEF     = 18;
  localparam int RD_LAT_DEF = 1;

  // A channel may be INFLIGHT and hold a newer PENDING entry at the same time.
  typedef enum logic [1:0] {
    CH_IDLE     = 2'd0,
    CH_PENDING  = 2'd1,
    CH_INFLIGHT = 2'd2
  } ch_state_e;

endpackage

// File: rtl/freqtable_arbiter_if.sv
// Client request/response bus plus external table-ROM port of the lookup arbiter.
interface freqtable_arbiter_if
  import freqtable_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int AW  = AW_DEF,
  parameter int DW  = DW_DEF
);
  logic [NCH-1:0]    req;
  logic [NCH*AW-1:0] addr;
  logic [NCH-1:0]    ack;
  logic [NCH*DW-1:0] rdata;
  logic              busy;
  logic              overrun;
  logic              mem_en;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_rdata;

  modport slave (
    input  req, addr, mem_rdata,
    output ack, rdata, busy, overrun, mem_en, mem_addr
  );

  modport master (
    output req, addr, mem_rdata,
    input  ack, rdata, busy, overrun, mem_en, mem_addr
  );
endinterface

// File: rtl/freqtable_arbiter_rr_arbiter.sv
// Round-robin selector: picks the first pending channel after last_grant, wrapping NCH-1 -> 0.
module rr_arbiter #(
  parameter int NCH = 16,
  parameter int IW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] pending,
  input  logic [IW-1:0]  last_grant,
  output logic           grant_valid,
  output logic [IW-1:0]  grant_idx
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  // Scan from the farthest offset down so the nearest pending channel is the last write.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    cand        = '0;
    for (int off = NCH; off >= 1; off--) begin
      sum = {1'b0, last_grant} + (IW+1)'(off);
      if (sum >= (IW+1)'(NCH)) sum = sum - (IW+1)'(NCH);
      cand = sum[IW-1:0];
      if (pending[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/freqtable_arbiter.sv
// Multi-channel table-lookup arbiter sharing one external ROM port with round-robin grants.
// Optional statistics counters grant_cnt/stall_cnt are built when FREQTABLE_ARB_STATS_EN is defined.
module freqtable_arbiter
  import freqtable_pkg::*;
#(
  parameter int NCH    = NCH_DEF,
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  freqtable_arbiter_if.slave  bus
`ifdef FREQTABLE_ARB_STATS_EN
  ,
  output logic [15:0]         grant_cnt,
  output logic [15:0]         stall_cnt
`endif
);

  localparam int IW = $clog2(NCH);

  logic [NCH-1:0] pending;
  logic [AW-1:0]  pending_addr [NCH];
  logic [IW-1:0]  last_grant;
  logic           grant_valid;
  logic [IW-1:0]  grant_idx;
  logic [RD_LAT-1:0] vld_p;
  logic [IW-1:0]  idx_p [RD_LAT];
  logic [IW-1:0]  idx_out;

  rr_arbiter #(.NCH(NCH), .IW(IW)) u_rr (
    .pending     (pending),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    bus.mem_en   = grant_valid;
    bus.mem_addr = grant_valid ? pending_addr[grant_idx] : '0;
  end

  assign bus.busy = (|pending) | (|vld_p);
  assign idx_out  = idx_p[RD_LAT-1];

  // Request capture and grant bookkeeping; a same-cycle request beats the grant clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending     <= '0;
      last_grant  <= IW'(NCH-1);
      bus.overrun <= 1'b0;
      for (int i = 0; i < NCH; i++) pending_addr[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (bus.req[i]) begin
          pending[i]      <= 1'b1;
          pending_addr[i] <= bus.addr[i*AW +: AW];
        end else if (grant_valid && grant_idx == IW'(i)) begin
          pending[i] <= 1'b0;
        end
      end
      if (grant_valid)          last_grant  <= grant_idx;
      if (|(bus.req & pending)) bus.overrun <= 1'b1;
    end
  end

  // Stage p0..p(RD_LAT-1): grant valid/index aligned with the ROM read latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= grant_valid;
      for (int s = 1; s < RD_LAT; s++) vld_p[s] <= vld_p[s-1];
    end
  end

  always_ff @(posedge clk) begin
    idx_p[0] <= grant_idx;
    for (int s = 1; s < RD_LAT; s++) idx_p[s] <= idx_p[s-1];
  end

  // Output stage: capture ROM data into the granted channel's slice and pulse its ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.ack   <= '0;
      bus.rdata <= '0;
    end else begin
      bus.ack <= '0;
      if (vld_p[RD_LAT-1]) begin
        bus.ack[idx_out]                   <= 1'b1;
        bus.rdata[int'(idx_out)*DW +: DW]  <= bus.mem_rdata;
      end
    end
  end

`ifdef FREQTABLE_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (grant_valid)              grant_cnt <= grant_cnt + 16'd1;
      if ($countones(pending) >= 2) stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_freqtable_arbiter.sv
// Scoreboard bench for freqtable_arbiter: directed scenarios plus random traffic against a rule-level model.
module tb_freqtable_arbiter;
  import freqtable_pkg::*;

  localparam int NCH    = 16;
  localparam int AW     = 10;
  localparam int DW     = 18;
  localparam int RD_LAT = 1;

  typedef struct {
    int            ch;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  freqtable_arbiter_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus ();

`ifdef FREQTABLE_ARB_STATS_EN
  logic [15:0] grant_cnt, stall_cnt;
`endif

  freqtable_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FREQTABLE_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] lookup(input logic [AW-1:0] a);
    return DW'(a) + DW'('h100);
  endfunction

  // Table ROM model: data appears RD_LAT cycles after mem_en.
  logic [DW-1:0] dl [RD_LAT];
  always @(posedge clk) begin
    dl[0] <= bus.mem_en ? lookup(bus.mem_addr) : '0;
    for (int k = 1; k < RD_LAT; k++) dl[k] <= dl[k-1];
  end
  assign bus.mem_rdata = dl[RD_LAT-1];

  // Reference model state.
  bit                mpend  [NCH];
  logic [AW-1:0]     mpaddr [NCH];
  int                mlast;
  bit                movr;
  int                ghist[$];
  exp_t              sbq[$];
  logic [NCH*DW-1:0] rmodel;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) begin
      mpend[i]  = 1'b0;
      mpaddr[i] = '0;
    end
    mlast  = NCH - 1;
    movr   = 1'b0;
    ghist.delete();
    sbq.delete();
    rmodel = '0;
  endtask

  // Called at a negedge; returns at a later negedge with the DUT released from reset.
  task automatic do_reset();
    rst      = 1'b0;
    bus.req  = '0;
    bus.addr = '0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_ack",      bus.ack,      '0);
    chk("rst_rdata",    bus.rdata,    '0);
    chk("rst_busy",     bus.busy,     '0);
    chk("rst_overrun",  bus.overrun,  '0);
    chk("rst_mem_en",   bus.mem_en,   '0);
    chk("rst_mem_addr", bus.mem_addr, '0);
    rst = 1'b1;
  endtask

  // One cycle: check this cycle's arbitration outputs against the model, then present new requests.
  task automatic step(input logic [NCH-1:0] r, input logic [NCH*AW-1:0] a);
    int g;
    bit bexp;
    g = -1;
    for (int off = 1; off <= NCH; off++) begin
      int c;
      c = (mlast + off) % NCH;
      if (g < 0 && mpend[c]) g = c;
    end
    bexp = 1'b0;
    for (int i = 0; i < NCH; i++) if (mpend[i]) bexp = 1'b1;
    foreach (ghist[k]) if (ghist[k] >= cyc - RD_LAT) bexp = 1'b1;
    chk("mem_en", bus.mem_en, (g >= 0));
    if (g >= 0) chk("mem_addr", bus.mem_addr, mpaddr[g]);
    else        chk("mem_addr_idle", bus.mem_addr, '0);
    chk("busy", bus.busy, bexp);
    chk("overrun", bus.overrun, movr);
    for (int i = 0; i < NCH; i++) if (r[i] && mpend[i]) movr = 1'b1;
    if (g >= 0) begin
      sbq.push_back('{ch: g, data: lookup(mpaddr[g]), cyc: cyc + 1 + RD_LAT});
      mpend[g] = 1'b0;
      mlast    = g;
      ghist.push_back(cyc);
      if (ghist.size() > RD_LAT + 1) void'(ghist.pop_front());
    end
    for (int i = 0; i < NCH; i++) begin
      if (r[i]) begin
        mpend[i]  = 1'b1;
        mpaddr[i] = a[i*AW +: AW];
      end
    end
    bus.req  = r;
    bus.addr = a;
    @(negedge clk);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sbq.size() > 0 || bus.busy) && k < 200) begin
      step('0, '0);
      k++;
    end
    chk("drain_bound", (k < 200), 1'b1);
    step('0, '0);
    step('0, '0);
    chk("sb_empty", sbq.size(), 0);
  endtask

  // Monitor: pop the expected response whenever an ack appears.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst) begin
      if (bus.ack != '0) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ack: got %0h expected none (cycle %0d)", bus.ack, cyc);
        end else begin
          mon_e = sbq.pop_front();
          chk("ack_vec",   bus.ack, NCH'(1) << mon_e.ch);
          chk("ack_cycle", cyc, mon_e.cyc);
          chk("ack_rdata", bus.rdata[mon_e.ch*DW +: DW], mon_e.data);
          rmodel[mon_e.ch*DW +: DW] = mon_e.data;
        end
      end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        mon_e = sbq.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missing_ack: got none expected ch%0d at cycle %0d (cycle %0d)", mon_e.ch, mon_e.cyc, cyc);
      end
      chk("rdata_hold", bus.rdata, rmodel);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  logic [NCH-1:0]    r;
  logic [NCH*AW-1:0] a;
  int                c0;
  int                ack_at;

  initial begin
    bus.req  = '0;
    bus.addr = '0;
    @(negedge clk);
    do_reset();

    // Single lookup on channel 3 with latency measurement.
    a = '0;
    a[3*AW +: AW] = AW'('h045);
    c0 = cyc;
    step(NCH'(1) << 3, a);
    ack_at = -1;
    for (int k = 0; k < 10 && ack_at < 0; k++) begin
      if (bus.ack[3]) ack_at = cyc;
      else step('0, '0);
    end
    chk("single_latency", ack_at - c0, 2 + RD_LAT);
    drain();
    chk("single_rdata3", bus.rdata[3*DW +: DW], DW'('h145));

    // All channels request together right after reset.
    do_reset();
    for (int i = 0; i < NCH; i++) a[i*AW +: AW] = AW'(i * 37 + 5);
    step('1, a);
    drain();
    chk("all_overrun", bus.overrun, 1'b0);

    // Fairness between two always-requesting channels.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      a = '0;
      a[2*AW +: AW] = AW'($urandom);
      a[5*AW +: AW] = AW'($urandom);
      step((NCH'(1) << 2) | (NCH'(1) << 5), a);
    end
    drain();
    chk("fair_overrun", bus.overrun, 1'b1);

    // Overwrite of a pending entry on channel 7 while 0..6 queue ahead.
    do_reset();
    for (int i = 0; i < NCH; i++) a[i*AW +: AW] = AW'($urandom);
    a[7*AW +: AW] = AW'('h010);
    step(NCH'(8'hFF), a);
    a = '0;
    a[7*AW +: AW] = AW'('h020);
    step(NCH'(1) << 7, a);
    drain();
    chk("ovr_rdata7", bus.rdata[7*DW +: DW], DW'('h120));
    chk("ovr_flag", bus.overrun, 1'b1);

    // Reset one cycle after the grant of channel 1: its read must vanish.
    do_reset();
    a = '0;
    a[0*AW +: AW] = AW'('h0AA);
    a[1*AW +: AW] = AW'('h0BB);
    step(NCH'(2'b11), a);
    step('0, '0);
    step('0, '0);
    do_reset();
    repeat (8) step('0, '0);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_rdata1", bus.rdata[1*DW +: DW], '0);

    // Random traffic.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      r = NCH'($urandom & $urandom);
      if ((k % 50) > 40) r = '0;
      for (int i = 0; i < NCH; i++) a[i*AW +: AW] = AW'($urandom);
      step(r, a);
    end
    drain();

`ifdef FREQTABLE_ARB_STATS_EN
    do_reset();
    for (int i = 0; i < NCH; i++) a[i*AW +: AW] = AW'($urandom);
    step('1, a);
    drain();
    chk("stats_grant_cnt", grant_cnt, 16'd16);
    chk("stats_stall_cnt", stall_cnt, 16'd15);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
